countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 129 ++++++++++++
 tb/tb_countdown_timer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer with load, start/pause control
// and a one-cycle expired pulse when the count reaches 000.
module countdown_timer #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_d0,
   input  logic [3:0] load_d1,
   input  logic [3:0] load_d2,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic       running,
   output logic       expired
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;

   logic [3:0] w_n0;
   logic [3:0] w_n1;
   logic [3:0] w_n2;
   logic       w_b0;
   logic       w_b1;
   logic       w_zero_now;
   logic       w_zero_next;
   logic       w_term;
   logic       w_go;

   function automatic logic [3:0] clamp9(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   // BCD decrement with borrow; only used while the count is non-zero
   always_comb begin
      w_b0 = (digit0 == 4'd0);
      w_n0 = w_b0 ? 4'd9 : digit0 - 4'd1;
      w_b1 = w_b0 && (digit1 == 4'd0);
      w_n1 = digit1;
      if (w_b0)
         w_n1 = (digit1 == 4'd0) ? 4'd9 : digit1 - 4'd1;
      w_n2 = w_b1 ? digit2 - 4'd1 : digit2;
      w_zero_now  = ({digit2, digit1, digit0} == 12'h000);
      w_zero_next = ({w_n2, w_n1, w_n0} == 12'h000);
      w_term = (r_presc == P_LAST);
      w_go   = start && !pause;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_presc <= '0;
         digit0  <= 4'd0;
         digit1  <= 4'd0;
         digit2  <= 4'd0;
         running <= 1'b0;
         expired <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (load) begin
            digit0  <= clamp9(load_d0);
            digit1  <= clamp9(load_d1);
            digit2  <= clamp9(load_d2);
            r_state <= IDLE;
            r_presc <= '0;
            running <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (w_go && !w_zero_now) begin
                     r_state <= RUN;
                     r_presc <= '0;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (w_term) begin
                     r_presc <= '0;
                     digit0  <= w_n0;
                     digit1  <= w_n1;
                     digit2  <= w_n2;
                     if (w_zero_next) begin
                        r_state <= DONE;
                        running <= 1'b0;
                        expired <= 1'b1;
                     end else if (pause) begin
                        r_state <= PAUSED;
                        running <= 1'b0;
                     end
                  end else if (pause) begin
                     // prescaler holds so resume continues the same tick
                     r_state <= PAUSED;
                     running <= 1'b0;
                  end else begin
                     r_presc <= r_presc + 1'b1;
                  end
               end
               PAUSED: begin
                  if (w_go) begin
                     r_state <= RUN;
                     running <= 1'b1;
                  end
               end
               DONE: begin
               end
               default: begin
                  r_state <= IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICK_DIV = 4; a negedge monitor
// compares every digit change against a queue of expected events.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_d0 = 4'd0;
   logic [3:0] load_d1 = 4'd0;
   logic [3:0] load_d2 = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic       running;
   logic       expired;

   typedef struct {
      logic [11:0] cnt;
      logic        exp;
   } ev_t;

   ev_t         exp_q[$];
   logic [11:0] m_cnt = 12'h000;
   logic [11:0] prev  = 12'h000;
   logic        mon_en = 1'b0;
   int          errors = 0;
   int          checks = 0;

   countdown_timer #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .load(load),
      .load_d0(load_d0), .load_d1(load_d1), .load_d2(load_d2),
      .start(start), .pause(pause),
      .digit0(digit0), .digit1(digit1), .digit2(digit2),
      .running(running), .expired(expired)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] cl(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   function automatic logic [11:0] cur();
      return {digit2, digit1, digit0};
   endfunction

   // Scoreboard side: every change of the digits, or any expired pulse
   always @(negedge clk) begin
      if (mon_en && (cur() !== prev || expired !== 1'b0)) begin
         ev_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got cnt=%h exp=%b, wanted no event",
                     cur(), expired);
         end else begin
            e = exp_q.pop_front();
            if (cur() !== e.cnt || expired !== e.exp) begin
               errors++;
               $display("FAIL sb_event: got cnt=%h exp=%b, wanted cnt=%h exp=%b",
                        cur(), expired, e.cnt, e.exp);
            end
         end
      end
      if (mon_en) prev = cur();
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] c, input logic x);
      ev_t e;
      if (c != m_cnt || x) begin
         e.cnt = c;
         e.exp = x;
         exp_q.push_back(e);
      end
      m_cnt = c;
   endtask

   task automatic do_load(input logic [3:0] a, b, c);
      load_d2 = a;
      load_d1 = b;
      load_d0 = c;
      load = 1'b1;
      push({cl(a), cl(b), cl(c)}, 1'b0);
      tick(1);
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load = 1'b1;
      load_d0 = 4'd5;
      load_d1 = 4'd5;
      load_d2 = 4'd5;
      tick(2);
      reset = 1'b0;
      load = 1'b0;
      checks++;
      if (cur() !== 12'h000) begin
         errors++;
         $display("FAIL reset_digits: got %h want 000", cur());
      end
      checks++;
      if (running !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got run=%b exp=%b want 0 0",
                  running, expired);
      end
      prev = 12'h000;
      mon_en = 1'b1;
   endtask

   task automatic test_countdown();
      do_load(4'd0, 4'd0, 4'd3);
      do_start();
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL cd_running: got %b want 1", running);
      end
      for (int k = 3; k > 0; k--) begin
         push(12'(k - 1), k == 1);
         tick(3);
         checks++;
         if (cur() !== 12'(k)) begin
            errors++;
            $display("FAIL cd_hold: got %h want %h", cur(), 12'(k));
         end
         tick(1);
         checks++;
         if (cur() !== 12'(k - 1) || expired !== (k == 1)) begin
            errors++;
            $display("FAIL cd_step: got %h exp=%b want %h exp=%b",
                     cur(), expired, 12'(k - 1), k == 1);
         end
      end
      tick(1);
      checks++;
      if (running !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL cd_after: got run=%b exp=%b want 0 0",
                  running, expired);
      end
   endtask

   task automatic test_borrow();
      logic [11:0] s [11];
      s = '{12'h099, 12'h098, 12'h097, 12'h096, 12'h095, 12'h094,
            12'h093, 12'h092, 12'h091, 12'h090, 12'h089};
      do_load(4'd1, 4'd0, 4'd0);
      do_start();
      for (int i = 0; i < 11; i++) push(s[i], 1'b0);
      tick(4);
      checks++;
      if (cur() !== 12'h099) begin
         errors++;
         $display("FAIL borrow_100: got %h want 099", cur());
      end
      tick(40);
      checks++;
      if (cur() !== 12'h089) begin
         errors++;
         $display("FAIL borrow_089: got %h want 089", cur());
      end
      do_load(4'd0, 4'd1, 4'd0);
      push(12'h009, 1'b0);
      do_start();
      tick(4);
      checks++;
      if (cur() !== 12'h009) begin
         errors++;
         $display("FAIL borrow_010: got %h want 009", cur());
      end
      do_load(4'd0, 4'd0, 4'd0);
   endtask

   task automatic test_pause();
      do_load(4'd0, 4'd0, 4'd5);
      do_start();
      tick(2);
      pause = 1'b1;
      tick(1);
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL pause_run: got %b want 0", running);
      end
      tick(9);
      pause = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      checks++;
      if (running !== 1'b1 || cur() !== 12'h005) begin
         errors++;
         $display("FAIL pause_resume: got run=%b cnt=%h want 1 005",
                  running, cur());
      end
      push(12'h004, 1'b0);
      tick(1);
      checks++;
      if (cur() !== 12'h005) begin
         errors++;
         $display("FAIL pause_early: got %h want 005", cur());
      end
      tick(1);
      checks++;
      if (cur() !== 12'h004) begin
         errors++;
         $display("FAIL pause_dec: got %h want 004", cur());
      end
      do_load(4'd0, 4'd0, 4'd0);
   endtask

   task automatic test_pause_terminal();
      do_load(4'd0, 4'd0, 4'd3);
      do_start();
      tick(3);
      pause = 1'b1;
      push(12'h002, 1'b0);
      tick(1);
      pause = 1'b0;
      checks++;
      if (cur() !== 12'h002 || running !== 1'b0) begin
         errors++;
         $display("FAIL pterm_pause: got cnt=%h run=%b want 002 0",
                  cur(), running);
      end
      do_start();
      push(12'h001, 1'b0);
      tick(3);
      checks++;
      if (cur() !== 12'h002) begin
         errors++;
         $display("FAIL pterm_clear: got %h want 002", cur());
      end
      tick(1);
      checks++;
      if (cur() !== 12'h001) begin
         errors++;
         $display("FAIL pterm_dec: got %h want 001", cur());
      end
      do_load(4'd0, 4'd0, 4'd0);
   endtask

   task automatic test_clamp();
      do_load(4'hF, 4'hA, 4'd9);
      checks++;
      if (cur() !== 12'h999) begin
         errors++;
         $display("FAIL clamp: got %h want 999", cur());
      end
      do_load(4'd0, 4'd0, 4'd0);
      do_start();
      tick(6);
      checks++;
      if (running !== 1'b0 || cur() !== 12'h000) begin
         errors++;
         $display("FAIL zero_start: got run=%b cnt=%h want 0 000",
                  running, cur());
      end
   endtask

   task automatic test_load_in_run();
      do_load(4'd0, 4'd0, 4'd3);
      do_start();
      push(12'h002, 1'b0);
      tick(4);
      do_load(4'd0, 4'd1, 4'd0);
      checks++;
      if (cur() !== 12'h010 || running !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL load_run: got cnt=%h run=%b exp=%b want 010 0 0",
                  cur(), running, expired);
      end
      do_start();
      tick(2);
      reset = 1'b1;
      load = 1'b1;
      load_d0 = 4'd7;
      load_d1 = 4'd7;
      load_d2 = 4'd7;
      push(12'h000, 1'b0);
      tick(1);
      reset = 1'b0;
      load = 1'b0;
      checks++;
      if (cur() !== 12'h000 || running !== 1'b0 || expired !== 1'b0) begin
         errors++;
         $display("FAIL reset_run: got cnt=%h run=%b exp=%b want 000 0 0",
                  cur(), running, expired);
      end
   endtask

   task automatic test_done();
      do_load(4'd0, 4'd0, 4'd1);
      do_start();
      push(12'h000, 1'b1);
      tick(4);
      checks++;
      if (expired !== 1'b1 || cur() !== 12'h000) begin
         errors++;
         $display("FAIL done_exp: got exp=%b cnt=%h want 1 000",
                  expired, cur());
      end
      start = 1'b1;
      pause = 1'b1;
      tick(1);
      pause = 1'b0;
      tick(3);
      start = 1'b0;
      checks++;
      if (running !== 1'b0 || expired !== 1'b0 || cur() !== 12'h000) begin
         errors++;
         $display("FAIL done_hold: got run=%b exp=%b cnt=%h want 0 0 000",
                  running, expired, cur());
      end
      do_load(4'd0, 4'd0, 4'd1);
      do_start();
      push(12'h000, 1'b1);
      tick(3);
      checks++;
      if (expired !== 1'b0) begin
         errors++;
         $display("FAIL reload_early: got %b want 0", expired);
      end
      tick(1);
      checks++;
      if (expired !== 1'b1) begin
         errors++;
         $display("FAIL reload_exp: got %b want 1", expired);
      end
   endtask

   initial begin
      tick(1);
      test_reset();
      test_countdown();
      test_borrow();
      test_pause();
      test_pause_terminal();
      test_clamp();
      test_load_in_run();
      test_done();
      tick(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
